// File: rtl/j1_io_uart_if.sv
// j1 CPU IO bus bundle between the CPU (master) and an IO responder (slave).
// Signals:
//   io_rd_i   - single-cycle IO read strobe
//   io_wr_i   - single-cycle IO write strobe
//   io_addr_i - CPU byte address
//   io_dout_i - write data from the CPU
//   io_din_o  - read data returned to the CPU (combinational in the responder)
// The _i/_o suffixes are seen from the responder side.
interface j1_io_uart_if;
  logic        io_rd_i;
  logic        io_wr_i;
  logic [31:0] io_addr_i;
  logic [31:0] io_dout_i;
  logic [31:0] io_din_o;

  modport master (output io_rd_i, io_wr_i, io_addr_i, io_dout_i, input io_din_o);
  modport slave  (input io_rd_i, io_wr_i, io_addr_i, io_dout_i, output io_din_o);
endinterface

// File: rtl/j1_io_uart.sv
// Memory-mapped 8N1 UART on the j1 IO bus: 16-byte window holding DATA (0x0),
// STATUS (0x4), DIVISOR (0x8) and a reserved word (0xC). TX and RX each have
// a FIFO_DEPTH-entry FIFO.
// Ports:
//   sys_clk_i   - system clock, rising edge
//   sys_rst_n_i - asynchronous active-low reset
//   io          - CPU IO bus (slave side)
//   uart_rx_i   - asynchronous serial input, idles high
//   uart_tx_o   - registered serial output, idles high
//   rx_irq_o    - high while the RX FIFO holds data
module j1_io_uart #(
  parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  j1_io_uart_if.slave io,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        rx_irq_o
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_DATA = 2'd2, ST_STOP = 2'd3} state_e;

  // Bus decode
  logic       sel_s, rd_data_s, wr_data_s, wr_stat_s, wr_div_s;
  logic [1:0] reg_s;
  logic       unused_bits_s;
  assign sel_s     = (io.io_addr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_s     = io.io_addr_i[3:2];
  assign rd_data_s = sel_s & io.io_rd_i & (reg_s == 2'd0);
  assign wr_data_s = sel_s & io.io_wr_i & (reg_s == 2'd0);
  assign wr_stat_s = sel_s & io.io_wr_i & (reg_s == 2'd1);
  assign wr_div_s  = sel_s & io.io_wr_i & (reg_s == 2'd2);
  assign unused_bits_s = ^{io.io_addr_i[1:0], io.io_dout_i[31:16], io.io_dout_i[4:0]};

  logic [15:0] div_r;
  logic        ovr_r, ferr_r, drop_r;

  // TX FIFO
  logic [7:0]  tx_mem_r [FIFO_DEPTH];
  logic [AW:0] tx_wp_r, tx_rp_r;
  logic        tx_empty_s, tx_full_s, tx_push_s, tx_load_s, tx_line_s;
  assign tx_empty_s = (tx_wp_r == tx_rp_r);
  assign tx_full_s  = (tx_wp_r[AW] != tx_rp_r[AW]) && (tx_wp_r[AW-1:0] == tx_rp_r[AW-1:0]);
  assign tx_push_s  = wr_data_s & ~tx_full_s;

  // RX FIFO
  logic [7:0]  rx_mem_r [FIFO_DEPTH];
  logic [AW:0] rx_wp_r, rx_rp_r;
  logic        rx_empty_s, rx_full_s, rx_pop_s, rx_req_s, rx_ferr_s, rx_push_s;
  assign rx_empty_s = (rx_wp_r == rx_rp_r);
  assign rx_full_s  = (rx_wp_r[AW] != rx_rp_r[AW]) && (rx_wp_r[AW-1:0] == rx_rp_r[AW-1:0]);
  assign rx_pop_s   = rd_data_s & ~rx_empty_s;
  assign rx_push_s  = rx_req_s & ~rx_full_s;
  assign rx_irq_o   = ~rx_empty_s;

  // Control registers: divisor (clamped to >= 2) and sticky flags, set beats clear
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      div_r  <= DIV_RESET;
      ovr_r  <= 1'b0;
      ferr_r <= 1'b0;
      drop_r <= 1'b0;
    end else begin
      if (wr_div_s) div_r <= (io.io_dout_i[15:0] < 16'd2) ? 16'd2 : io.io_dout_i[15:0];
      else          div_r <= div_r;
      ovr_r  <= (rx_req_s & rx_full_s)  | (ovr_r  & ~(wr_stat_s & io.io_dout_i[5]));
      ferr_r <= rx_ferr_s               | (ferr_r & ~(wr_stat_s & io.io_dout_i[6]));
      drop_r <= (wr_data_s & tx_full_s) | (drop_r & ~(wr_stat_s & io.io_dout_i[7]));
    end
  end

  // FIFO pointers; full/empty come from start-of-cycle state so a push to full is dropped
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      tx_wp_r <= '0;
      tx_rp_r <= '0;
      rx_wp_r <= '0;
      rx_rp_r <= '0;
    end else begin
      tx_wp_r <= tx_push_s ? tx_wp_r + PTR_ONE : tx_wp_r;
      tx_rp_r <= tx_load_s ? tx_rp_r + PTR_ONE : tx_rp_r;
      rx_wp_r <= rx_push_s ? rx_wp_r + PTR_ONE : rx_wp_r;
      rx_rp_r <= rx_pop_s  ? rx_rp_r + PTR_ONE : rx_rp_r;
    end
  end

  logic [7:0] rx_shift_r;

  // FIFO storage, not reset: contents are only visible through the pointers
  always_ff @(posedge sys_clk_i) begin
    if (tx_push_s) tx_mem_r[tx_wp_r[AW-1:0]] <= io.io_dout_i[7:0];
    if (rx_push_s) rx_mem_r[rx_wp_r[AW-1:0]] <= rx_shift_r;
  end

  // ---------------- TX serialiser ----------------
  state_e      tx_state_r, tx_state_s;
  logic [15:0] tx_cnt_r, tx_bdiv_r;
  logic [2:0]  tx_bit_r;
  logic [7:0]  tx_shift_r;
  logic        tx_end_s;
  assign tx_end_s = (tx_cnt_r == tx_bdiv_r - 16'd1);

  // TX state register
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) tx_state_r <= ST_IDLE;
    else              tx_state_r <= tx_state_s;
  end

  // TX next state; STOP goes straight to START when more data is queued
  always_comb begin
    tx_state_s = tx_state_r;
    case (tx_state_r)
      ST_IDLE:  if (!tx_empty_s) tx_state_s = ST_START; else tx_state_s = ST_IDLE;
      ST_START: if (tx_end_s) tx_state_s = ST_DATA; else tx_state_s = ST_START;
      ST_DATA:  if (tx_end_s && tx_bit_r == 3'd7) tx_state_s = ST_STOP; else tx_state_s = ST_DATA;
      ST_STOP: begin
        if (tx_end_s) tx_state_s = tx_empty_s ? ST_IDLE : ST_START;
        else          tx_state_s = ST_STOP;
      end
      default:  tx_state_s = ST_IDLE;
    endcase
  end

  // TX outputs: FIFO pop/shifter load and the line level for the current state
  always_comb begin
    tx_load_s = 1'b0;
    tx_line_s = 1'b1;
    case (tx_state_r)
      ST_IDLE:  tx_load_s = (tx_state_s == ST_START);
      ST_START: tx_line_s = 1'b0;
      ST_DATA:  tx_line_s = tx_shift_r[0];
      ST_STOP:  tx_load_s = (tx_state_s == ST_START);
      default:  tx_line_s = 1'b1;
    endcase
  end

  // TX datapath; the line is registered one cycle behind the state, and the
  // divisor is latched per bit so a new value applies at the next bit boundary
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      uart_tx_o  <= 1'b1;
      tx_cnt_r   <= 16'd0;
      tx_bdiv_r  <= DIV_RESET;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
    end else begin
      uart_tx_o <= tx_line_s;
      if (tx_load_s) begin
        tx_shift_r <= tx_mem_r[tx_rp_r[AW-1:0]];
        tx_cnt_r   <= 16'd0;
        tx_bdiv_r  <= div_r;
        tx_bit_r   <= 3'd0;
      end else if (tx_state_r != ST_IDLE) begin
        if (tx_end_s) begin
          tx_cnt_r  <= 16'd0;
          tx_bdiv_r <= div_r;
          if (tx_state_r == ST_DATA) begin
            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            tx_bit_r   <= tx_bit_r + 3'd1;
          end
        end else begin
          tx_cnt_r <= tx_cnt_r + 16'd1;
        end
      end else begin
        tx_cnt_r <= 16'd0;
      end
    end
  end

  // ---------------- RX deserialiser ----------------
  state_e      rx_state_r, rx_state_s;
  logic [15:0] rx_cnt_r, rx_bdiv_r;
  logic [2:0]  rx_bit_r;
  logic        rx_meta_r, rx_sync_r, rx_prev_r;
  logic        rx_end_s, rx_half_s;
  assign rx_end_s  = (rx_cnt_r == rx_bdiv_r - 16'd1);
  // The +2 absorbs the synchronizer and edge-detect cycles so the start
  // sample falls DIVISOR/2 clocks into the start bit.
  assign rx_half_s = (({1'b0, rx_cnt_r} + 17'd2) >= {2'b00, rx_bdiv_r[15:1]});

  // RX synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx_i;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // RX state register
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) rx_state_r <= ST_IDLE;
    else              rx_state_r <= rx_state_s;
  end

  // RX next state; a high start sample is a false start
  always_comb begin
    rx_state_s = rx_state_r;
    case (rx_state_r)
      ST_IDLE:  if (!rx_sync_r && rx_prev_r) rx_state_s = ST_START; else rx_state_s = ST_IDLE;
      ST_START: begin
        if (rx_half_s) rx_state_s = rx_sync_r ? ST_IDLE : ST_DATA;
        else           rx_state_s = ST_START;
      end
      ST_DATA:  if (rx_end_s && rx_bit_r == 3'd7) rx_state_s = ST_STOP; else rx_state_s = ST_DATA;
      ST_STOP:  if (rx_end_s) rx_state_s = ST_IDLE; else rx_state_s = ST_STOP;
      default:  rx_state_s = ST_IDLE;
    endcase
  end

  // RX outputs: stop-bit verdict (push request or framing error)
  always_comb begin
    rx_req_s  = 1'b0;
    rx_ferr_s = 1'b0;
    case (rx_state_r)
      ST_STOP: begin
        rx_req_s  = rx_end_s & rx_sync_r;
        rx_ferr_s = rx_end_s & ~rx_sync_r;
      end
      default: begin
        rx_req_s  = 1'b0;
        rx_ferr_s = 1'b0;
      end
    endcase
  end

  // RX datapath: bit timing and LSB-first shift register
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rx_cnt_r   <= 16'd0;
      rx_bdiv_r  <= DIV_RESET;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
    end else begin
      case (rx_state_r)
        ST_IDLE: begin
          rx_cnt_r  <= 16'd0;
          rx_bdiv_r <= div_r;
          rx_bit_r  <= 3'd0;
        end
        ST_START: begin
          if (rx_half_s) begin
            rx_cnt_r  <= 16'd0;
            rx_bdiv_r <= div_r;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_end_s) begin
            rx_cnt_r   <= 16'd0;
            rx_bdiv_r  <= div_r;
            rx_bit_r   <= rx_bit_r + 3'd1;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        ST_STOP: rx_cnt_r <= rx_end_s ? 16'd0 : rx_cnt_r + 16'd1;
        default: rx_cnt_r <= 16'd0;
      endcase
    end
  end

  // Read mux; DATA shows zero payload when the RX FIFO is empty
  always_comb begin
    io.io_din_o = 32'h0000_0000;
    if (sel_s) begin
      case (reg_s)
        2'd0:    io.io_din_o = {23'd0, ~rx_empty_s, rx_empty_s ? 8'h00 : rx_mem_r[rx_rp_r[AW-1:0]]};
        2'd1:    io.io_din_o = {24'd0, drop_r, ferr_r, ovr_r, (tx_state_r != ST_IDLE),
                                tx_full_s, tx_empty_s, rx_full_s, ~rx_empty_s};
        2'd2:    io.io_din_o = {16'd0, div_r};
        default: io.io_din_o = 32'h0000_0000;
      endcase
    end else begin
      io.io_din_o = 32'h0000_0000;
    end
  end
endmodule

// File: tb/tb_j1_io_uart.sv
// Self-checking bench for j1_io_uart: register table, TX waveform, loopback,
// FIFO boundaries, framing/false-start cases, reset mid-frame, and random
// loopback batches checked against a queue model of the byte stream.
module tb_j1_io_uart;
  localparam logic [31:0] R_DATA = 32'hF000_0000;
  localparam logic [31:0] R_STAT = 32'hF000_0004;
  localparam logic [31:0] R_DIV  = 32'hF000_0008;
  localparam logic [31:0] R_RSV  = 32'hF000_000C;

  logic clk = 1'b0;
  logic rst_n, tb_rx, loop_en, rx_line, tx, irq;
  int   total = 0;
  int   bad   = 0;

  j1_io_uart_if bus();

  j1_io_uart #(.BASE_ADDR(32'hF000_0000), .FIFO_DEPTH(16), .DIV_RESET(16'd434)) dut (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .io(bus),
    .uart_rx_i(rx_line), .uart_tx_o(tx), .rx_irq_o(irq)
  );

  always #5 clk = ~clk;
  assign rx_line = loop_en ? tx : tb_rx;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.io_wr_i = 1'b1; bus.io_addr_i = a; bus.io_dout_i = d;
    @(posedge clk); #1;
    bus.io_wr_i = 1'b0;
  endtask

  task automatic io_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.io_rd_i = 1'b1; bus.io_addr_i = a;
    #1 d = bus.io_din_o;
    @(posedge clk); #1;
    bus.io_rd_i = 1'b0;
  endtask

  task automatic read_check(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    io_read(a, d);
    check(nm, d, exp);
  endtask

  task automatic wait_tx_idle();
    logic [31:0] s;
    int n;
    n = 0; s = 32'd0;
    do begin
      io_read(R_STAT, s);
      n++;
    end while (!(s[2] && !s[4]) && n < 4000);
    check("tx_idle_wait", {31'd0, s[2] & ~s[4]}, 32'd1);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int d);
    @(negedge clk);
    tb_rx = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tb_rx = b[i];
      repeat (d) @(negedge clk);
    end
    tb_rx = stop_bit;
    repeat (d) @(negedge clk);
    tb_rx = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [9:0]  fr;
    logic [7:0]  b;
    logic        ok, ovr_exp;
    logic [7:0]  rxq[$];
    int          d, n, cyc;

    rst_n = 1'b0; tb_rx = 1'b1; loop_en = 1'b0;
    bus.io_rd_i = 1'b0; bus.io_wr_i = 1'b0; bus.io_addr_i = 32'd0; bus.io_dout_i = 32'd0;

    // register access table: {wr, addr, wdata, expected read}
    vecs[0]  = '{1'b0, R_STAT,        32'd0,         32'h0000_0004};
    vecs[1]  = '{1'b0, R_DIV,         32'd0,         32'd434};
    vecs[2]  = '{1'b0, R_DATA,        32'd0,         32'd0};
    vecs[3]  = '{1'b1, R_RSV,         32'hFFFF_FFFF, 32'd0};
    vecs[4]  = '{1'b0, R_RSV,         32'd0,         32'd0};
    vecs[5]  = '{1'b1, R_DIV,         32'd1,         32'd0};
    vecs[6]  = '{1'b0, R_DIV,         32'd0,         32'd2};
    vecs[7]  = '{1'b1, R_DIV,         32'h1234_0008, 32'd0};
    vecs[8]  = '{1'b0, R_DIV,         32'd0,         32'd8};
    vecs[9]  = '{1'b1, 32'hF000_0018, 32'd3,         32'd0};
    vecs[10] = '{1'b0, 32'hF000_000B, 32'd0,         32'd8};
    vecs[11] = '{1'b0, 32'hE000_0004, 32'd0,         32'd0};
    vecs[12] = '{1'b1, R_STAT,        32'h0000_00FF, 32'd0};
    vecs[13] = '{1'b0, R_STAT,        32'd0,         32'h0000_0004};

    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_din", bus.io_din_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) io_write(vecs[i].addr, vecs[i].data);
      else begin
        io_read(vecs[i].addr, rd);
        check($sformatf("regvec[%0d]", i), rd, vecs[i].exp);
      end
    end

    // TX waveform for 0xA5 at divisor 8; line falls on the 2nd edge after the write
    io_write(R_DATA, 32'h0000_00A5);
    @(posedge clk); #1;
    check("tx_lat_edge1", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    check("tx_lat_edge2", {31'd0, tx}, 32'd0);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int bi = 0; bi < 10; bi++) begin
      ok = 1'b1;
      for (int c = 0; c < 8; c++) begin
        if (bi != 0 || c != 0) begin
          @(posedge clk); #1;
        end
        if (tx !== fr[bi]) ok = 1'b0;
      end
      check($sformatf("tx_bit%0d_8clk", bi), {31'd0, ok}, 32'd1);
    end
    @(posedge clk); #1;
    check("tx_after_stop", {31'd0, tx}, 32'd1);
    wait_tx_idle();

    // loopback 0x3C, 0xFF
    @(negedge clk);
    loop_en = 1'b1;
    io_write(R_DATA, 32'h0000_003C);
    io_write(R_DATA, 32'h0000_00FF);
    wait_tx_idle();
    repeat (20) @(negedge clk);
    check("loop_irq_set", {31'd0, irq}, 32'd1);
    read_check("loop_rd0", R_DATA, 32'h0000_013C);
    read_check("loop_rd1", R_DATA, 32'h0000_01FF);
    read_check("loop_rd_empty", R_DATA, 32'h0000_0000);
    check("loop_irq_clr", {31'd0, irq}, 32'd0);

    // TX FIFO boundary: first byte moves to the shifter, 16 more fill the FIFO
    @(negedge clk);
    loop_en = 1'b0;
    for (int i = 0; i < 17; i++) io_write(R_DATA, i);
    read_check("tx_full_nodrop", R_STAT, 32'h0000_0018);
    io_write(R_DATA, 32'd17);
    read_check("tx_drop_set", R_STAT, 32'h0000_0098);
    io_write(R_STAT, 32'h0000_0080);
    read_check("tx_drop_clr", R_STAT, 32'h0000_0018);

    // asynchronous reset in the middle of a frame
    cyc = 0;
    while (tx !== 1'b0 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("tx_low_before_rst", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    read_check("rst_mid_stat", R_STAT, 32'h0000_0004);
    read_check("rst_mid_div", R_DIV, 32'd434);
    repeat (100) @(negedge clk);
    check("rst_tx_quiet", {31'd0, tx}, 32'd1);

    // framing error and false start with tb-driven line at divisor 8
    io_write(R_DIV, 32'd8);
    drive_frame(8'h96, 1'b0, 8);
    repeat (16) @(negedge clk);
    read_check("ferr_stat", R_STAT, 32'h0000_0044);
    read_check("ferr_nopush", R_DATA, 32'd0);
    io_write(R_STAT, 32'h0000_0040);
    read_check("ferr_clr", R_STAT, 32'h0000_0004);
    @(negedge clk);
    tb_rx = 1'b0;
    repeat (3) @(negedge clk);
    tb_rx = 1'b1;
    repeat (30) @(negedge clk);
    read_check("glitch_stat", R_STAT, 32'h0000_0004);
    read_check("glitch_nopush", R_DATA, 32'd0);
    drive_frame(8'h5A, 1'b1, 8);
    repeat (16) @(negedge clk);
    read_check("rx_after_glitch", R_DATA, 32'h0000_015A);

    // random loopback batches against a queue model; last batch overruns RX
    @(negedge clk);
    loop_en = 1'b1;
    ovr_exp = 1'b0;
    for (int batch = 0; batch < 4; batch++) begin
      d = $urandom_range(12, 4);
      n = (batch == 3) ? 17 : $urandom_range(16, 1);
      io_write(R_DIV, d);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(255, 0));
        io_write(R_DATA, {24'd0, b});
        if (rxq.size() < 16) rxq.push_back(b);
        else ovr_exp = 1'b1;
      end
      wait_tx_idle();
      repeat (2 * d + 4) @(negedge clk);
      read_check($sformatf("rnd%0d_stat", batch), R_STAT,
                 32'h4 | ((rxq.size() > 0) ? 32'h1 : 32'h0) |
                 ((rxq.size() == 16) ? 32'h2 : 32'h0) | (ovr_exp ? 32'h20 : 32'h0));
      while (rxq.size() > 0) begin
        b = rxq.pop_front();
        read_check($sformatf("rnd%0d_data", batch), R_DATA, {23'd0, 1'b1, b});
      end
      read_check($sformatf("rnd%0d_empty", batch), R_DATA, 32'd0);
      if (ovr_exp) begin
        io_write(R_STAT, 32'h0000_0020);
        ovr_exp = 1'b0;
        read_check($sformatf("rnd%0d_ovr_clr", batch), R_STAT, 32'h0000_0004);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
